seg_mux_receiver: RTL and testbench
===================================

SEG_MUX_RECEIVER -- requirements
Module: seg_mux_receiver

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, 8: cycles a select phase is stable before its segments are sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 150000: cycles without a select transition before link_lost is raised.
REQ-003 click  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 select_dp1, select_dp2  input  1 each  digit-enable lines from the multiplexed display bus; active-high.
REQ-006 a_in, b_in, c_in, d_in, e_in, f_in, g_in, dp_in  input  1 each  segment lines; active-low (0 = lit).
REQ-007 digit1, digit2  output  4 each  last decoded digit for phase 1 and phase 2.
REQ-008 pair_valid  output  1  one-cycle pulse when a new digit1/digit2 pair is updated.
REQ-009 code_err  output  1  sticky; set on any unrecognized segment pattern.
REQ-010 link_lost  output  1  high while no select transition occurs within TIMEOUT_CYCLES.

Function
REQ-011 All 10 bus inputs SHALL pass through a two-flop synchronizer; all logic SHALL use only synchronized values.
REQ-012 Phase SHALL be P1 when {select_dp1,select_dp2}=10, P2 when 01, INVALID otherwise.
REQ-013 FSM states SHALL be HUNT, SETTLE1, HOLD1, SETTLE2, HOLD2.
REQ-014 HUNT: on entry to P1, go to SETTLE1 with settle counter cleared; all other phases remain in HUNT.
REQ-015 SETTLEn: counter increments each cycle in phase n; at SETTLE_CYCLES-1, sample {g..a}, decode, go to HOLDn.
REQ-016 HOLD1: on entry to P2, go to SETTLE2. HOLD2: on entry to P1, go to SETTLE1.
REQ-017 Any INVALID phase, or a phase change before settling completes, SHALL return to HUNT and discard the partial pair.
REQ-018 Decode table {g,f,e,d,c,b,a} hex: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10; dp_in ignored.
REQ-019 Phase-1 sample SHALL be held internally; at the phase-2 sample, if both are valid, digit1/digit2 SHALL update and pair_valid SHALL pulse the following cycle (latency SETTLE_CYCLES+1 after P2 entry, excluding the 2-cycle synchronizer).
REQ-020 If either sample is unrecognized, digit1/digit2 SHALL hold, pair_valid SHALL stay low, code_err SHALL set, and the FSM SHALL return to HUNT.
REQ-021 Timeout counter SHALL clear on every synchronized select transition and saturate at TIMEOUT_CYCLES; link_lost = saturated.
REQ-022 link_lost rising SHALL force HUNT; it SHALL clear on the next select transition, and digits SHALL update only after a full pair.
REQ-023 code_err SHALL clear only on reset.

Reset
REQ-024 On reset low: FSM=HUNT; digit1=digit2=0; pair_valid=0; code_err=0; link_lost=0; all counters and synchronizers 0.
REQ-025 Reset asserted mid-pair SHALL discard the pair; after release, no pair_valid before a full P1 then P2 sequence.

Configuration
REQ-026 Macro SEG_HEX_DECODE_EN: when defined, decode SHALL add A=08, b=03, C=46, d=21, E=06, F=0E (values 10-15).
REQ-027 Without SEG_HEX_DECODE_EN, those six patterns SHALL be unrecognized and set code_err.

Verification
REQ-028 Bus toggles P1/P2 every 50000 cycles; segs 79 in P1, 24 in P2 -> digit1=1, digit2=2, one pair_valid per P1+P2 cycle.
REQ-029 P2 segments 7F (blank) -> code_err=1, digits hold previous values, no pair_valid.
REQ-030 selects held at 11 for 200000 cycles -> link_lost=1 at 150000 cycles without transition, FSM in HUNT; resume toggling -> link_lost=0, pair_valid after next P1+P2.
REQ-031 P1 held for only 4 cycles before switching to P2 (SETTLE_CYCLES=8) -> FSM returns to HUNT, no digit update.
REQ-032 Reset pulsed during SETTLE2 -> all outputs 0, first pair_valid only after a full subsequent pair.
REQ-033 Segs 08/0E with SEG_HEX_DECODE_EN -> digit1=A, digit2=F; without it -> code_err=1.

Source files
------------

// File: rtl/seg_mux_receiver.sv
// seg_mux_receiver: decodes a two-digit multiplexed 7-segment display bus into a validated digit pair.
// Define SEG_HEX_DECODE_EN to also accept the hex glyphs A, b, C, d, E, F as values 10-15.
module seg_mux_receiver #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       click,
  input  logic       reset,
  input  logic       select_dp1,
  input  logic       select_dp2,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       c_in,
  input  logic       d_in,
  input  logic       e_in,
  input  logic       f_in,
  input  logic       g_in,
  input  logic       dp_in,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       pair_valid,
  output logic       code_err,
  output logic       link_lost
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {HUNT, SETTLE1, HOLD1, SETTLE2, HOLD2} state_t;
  state_t state, state_nx;
  logic [9:0] s1, s2;
  logic [1:0] sel_q;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt;
  logic [3:0] d1_hold, dec;
  logic dec_ok, p1, p2, trans, ph_ok, done, sample, unused_dp;
  assign p1 = s2[9:8] == 2'b10;
  assign p2 = s2[9:8] == 2'b01;
  assign trans = s2[9:8] != sel_q;
  assign ph_ok = (state == SETTLE1) ? p1 : p2;
  assign done = cnt == CW'(SETTLE_CYCLES - 1);
  assign link_lost = tcnt == TW'(TIMEOUT_CYCLES);
  assign unused_dp = s2[7];
  always_comb begin
    dec = 4'd0;
    dec_ok = 1'b1;
    case (s2[6:0])
      7'h40: dec = 4'd0;
      7'h79: dec = 4'd1;
      7'h24: dec = 4'd2;
      7'h30: dec = 4'd3;
      7'h19: dec = 4'd4;
      7'h12: dec = 4'd5;
      7'h02: dec = 4'd6;
      7'h78: dec = 4'd7;
      7'h00: dec = 4'd8;
      7'h10: dec = 4'd9;
`ifdef SEG_HEX_DECODE_EN
      7'h08: dec = 4'd10;
      7'h03: dec = 4'd11;
      7'h46: dec = 4'd12;
      7'h21: dec = 4'd13;
      7'h06: dec = 4'd14;
      7'h0E: dec = 4'd15;
`endif
      default: dec_ok = 1'b0;
    endcase
  end
  // A lost link parks the FSM in HUNT, but the transition that revives the link is still honoured.
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    sample = 1'b0;
    if (link_lost && !trans) state_nx = HUNT;
    else case (state)
      HUNT: state_nx = (p1 && trans) ? SETTLE1 : HUNT;
      SETTLE1, SETTLE2: begin
        cnt_nx = cnt + 1'b1;
        sample = ph_ok && done;
        state_nx = (!ph_ok || (done && !dec_ok)) ? HUNT : !done ? state : (state == SETTLE1) ? HOLD1 : HOLD2;
      end
      HOLD1: state_nx = p2 ? SETTLE2 : p1 ? HOLD1 : HUNT;
      HOLD2: state_nx = p1 ? SETTLE1 : p2 ? HOLD2 : HUNT;
      default: state_nx = HUNT;
    endcase
  end
  always_ff @(posedge click or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      sel_q <= '0;
      state <= HUNT;
      cnt <= '0;
      tcnt <= '0;
      d1_hold <= '0;
      digit1 <= '0;
      digit2 <= '0;
      pair_valid <= 1'b0;
      code_err <= 1'b0;
    end else begin
      s1 <= {select_dp1, select_dp2, dp_in, g_in, f_in, e_in, d_in, c_in, b_in, a_in};
      s2 <= s1;
      sel_q <= s2[9:8];
      state <= state_nx;
      cnt <= cnt_nx;
      tcnt <= trans ? '0 : link_lost ? tcnt : tcnt + 1'b1;
      pair_valid <= sample && dec_ok && state == SETTLE2;
      if (sample && !dec_ok) code_err <= 1'b1;
      if (sample && dec_ok && state == SETTLE1) d1_hold <= dec;
      if (sample && dec_ok && state == SETTLE2) begin
        digit1 <= d1_hold;
        digit2 <= dec;
      end
    end
  end
endmodule

// File: tb/tb_seg_mux_receiver.sv
// tb_seg_mux_receiver: random and directed bus segments scored against a segment-level model of the receiver.
module tb_seg_mux_receiver;
  localparam int S = 8, TO = 400;
  logic click = 0, reset = 0, select_dp1 = 0, select_dp2 = 0, dp = 0;
  logic [6:0] segs = 7'h7F;
  logic [3:0] digit1, digit2;
  logic pair_valid, code_err, link_lost;
  seg_mux_receiver #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .click(click), .reset(reset), .select_dp1(select_dp1), .select_dp2(select_dp2),
    .a_in(segs[0]), .b_in(segs[1]), .c_in(segs[2]), .d_in(segs[3]), .e_in(segs[4]),
    .f_in(segs[5]), .g_in(segs[6]), .dp_in(dp),
    .digit1(digit1), .digit2(digit2), .pair_valid(pair_valid), .code_err(code_err), .link_lost(link_lost)
  );
  always #5 click = ~click;
  int checks = 0, fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  logic [1:0] prev = 2'b00;
  bit armed = 0, swallow = 0, err_exp = 0;
  logic [3:0] d1 = 0, last1 = 0, last2 = 0;
  localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  function automatic int lookup(input logic [6:0] p);
    int n;
`ifdef SEG_HEX_DECODE_EN
    n = 16;
`else
    n = 10;
`endif
    for (int i = 0; i < n; i++) if (TBL[i] == p) return i;
    return -1;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic hold(input logic [1:0] sel, input logic [6:0] pat, input int len);
    {select_dp1, select_dp2} = sel;
    segs = pat;
    dp = 1'($urandom);
    repeat (len) @(posedge click);
    #1;
  endtask
  // A phase yields a sample only if it lasts more than S cycles; a P1 digit waits for the next P2 digit.
  task automatic seg_step(input logic [1:0] sel, input logic [6:0] pat, input int len);
    int v;
    bit sw;
    v = lookup(pat);
    sw = 0;
    if (sel == 2'b10) begin
      armed = 0;
      if (prev != 2'b10 && !swallow && len > S) begin
        if (v < 0) err_exp = 1;
        else begin
          armed = (len <= TO + 1);
          d1 = 4'(v);
        end
      end
    end else if (sel == 2'b01 && armed) begin
      armed = 0;
      if (len <= S) sw = 1;
      else if (v < 0) err_exp = 1;
      else begin
        exp_q.push_back({d1, 4'(v)});
        last1 = d1;
        last2 = 4'(v);
      end
    end else armed = 0;
    swallow = sw;
    prev = sel;
    hold(sel, pat, len);
  endtask
  task automatic checkpoint(input string tag);
    seg_step(2'b00, 7'h7F, 6);
    check({tag, "_code_err"}, code_err, err_exp);
    check({tag, "_link_lost"}, link_lost, 0);
    check({tag, "_digits"}, {digit1, digit2}, {last1, last2});
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask
  task automatic do_reset(input logic [1:0] sel);
    {select_dp1, select_dp2} = sel;
    reset = 0;
    repeat (3) @(posedge click);
    #1;
    check("rst_outputs", {digit1, digit2, pair_valid, code_err, link_lost}, 0);
    reset = 1;
    armed = 0;
    swallow = 0;
    err_exp = 0;
    last1 = 0;
    last2 = 0;
    prev = sel;
    repeat (4) @(posedge click);
    #1;
  endtask
  always @(negedge click) if (reset && pair_valid) begin
    if (exp_q.size() == 0) check("unexpected_pair", {digit1, digit2}, -1);
    else begin
      mon_e = exp_q.pop_front();
      check("pair", {digit1, digit2}, mon_e);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] sel;
    logic [6:0] pat;
    @(posedge click);
    #1;
    do_reset(2'b00);
    for (int i = 0; i < 3; i++) begin
      seg_step(2'b10, 7'h79, 20);
      seg_step(2'b01, 7'h24, 20);
    end
    checkpoint("toggle");
    seg_step(2'b10, 7'h78, S + 1);
    seg_step(2'b01, 7'h10, S + 1);
    seg_step(2'b10, 7'h12, S);
    seg_step(2'b01, 7'h40, S + 1);
    checkpoint("boundary");
    seg_step(2'b10, 7'h12, 4);
    seg_step(2'b01, 7'h24, 12);
    checkpoint("short_p1");
    seg_step(2'b10, 7'h79, 12);
    seg_step(2'b01, 7'h24, 12);
    seg_step(2'b11, 7'h7F, TO + 20);
    check("link_lost_set", link_lost, 1);
    hold(2'b11, 7'h7F, 50);
    check("link_lost_held", link_lost, 1);
    seg_step(2'b10, 7'h79, 12);
    seg_step(2'b01, 7'h30, 12);
    checkpoint("relink");
    seg_step(2'b10, 7'h19, TO + 50);
    seg_step(2'b01, 7'h24, 12);
    checkpoint("long_p1");
    seg_step(2'b10, 7'h79, 12);
    seg_step(2'b01, 7'h7F, 12);
    checkpoint("blank_p2");
    do_reset(2'b00);
    seg_step(2'b10, 7'h79, 12);
    {select_dp1, select_dp2} = 2'b01;
    segs = 7'h24;
    repeat (6) @(posedge click);
    #1;
    do_reset(2'b01);
    seg_step(2'b10, 7'h02, 12);
    seg_step(2'b01, 7'h30, 12);
    checkpoint("mid_reset");
    do_reset(2'b00);
    seg_step(2'b10, 7'h08, 12);
    seg_step(2'b01, 7'h0E, 12);
    checkpoint("hex");
    for (int b = 0; b < 4; b++) begin
      do_reset(2'b00);
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 9) < 7) sel = (prev == 2'b10) ? 2'b01 : 2'b10;
        else begin
          sel = 2'($urandom);
          while (sel == prev) sel = 2'($urandom);
        end
        pat = ($urandom_range(0, 99) < 85) ? TBL[$urandom_range(0, 9)] : 7'($urandom);
        seg_step(sel, pat, $urandom_range(2, 24));
        if (n % 10 == 9) checkpoint("random");
      end
    end
    repeat (5) @(posedge click);
    #1;
    check("final_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
